// File: rtl/sr_lifo_pkg.sv
// Shared sizing and opcode constants for the CPU and the sr_lifo stack.
// Both sides import this package so stack geometry and push/pop encoding stay in sync.
package sr_lifo_pkg;

  localparam int   LIFO_WIDTH = 16;
  localparam int   LIFO_DEPTH = 16;
  localparam logic OP_PUSH    = 1'b1;
  localparam logic OP_POP     = 1'b0;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_PUSH,
    ACT_POP,
    ACT_OVF,
    ACT_UDF
  } act_e;

  // Classifies the requested operation against the current fill state
  function automatic act_e decodeOp(logic en, logic mode, logic isFull, logic isEmpty);
    act_e act;
    act = ACT_NONE;
    if (en) begin
      if (mode == OP_PUSH) act = isFull  ? ACT_OVF : ACT_PUSH;
      else                 act = isEmpty ? ACT_UDF : ACT_POP;
    end
    return act;
  endfunction

endpackage

// File: rtl/sr_lifo_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module sr_lifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int MAW   = 4
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [MAW-1:0]   wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [MAW-1:0]   rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/sr_lifo.sv
// LIFO stack with first-word-fall-through top output, saturating entry count
// and sticky overflow/underflow flags.
module sr_lifo
  import sr_lifo_pkg::*;
#(
  parameter int WIDTH = LIFO_WIDTH,
  parameter int DEPTH = LIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty,
  output logic             full,
  output logic [AW-1:0]    amount,
  output logic             ovf,
  output logic             udf
);

  localparam int MAW = $clog2(DEPTH);

  logic [AW-1:0]    sp;
  logic             ovfQ;
  logic             udfQ;
  act_e             act;
  logic [MAW-1:0]   wrAddr;
  logic [MAW-1:0]   rdAddr;
  logic [WIDTH-1:0] rdData;

  assign empty  = (sp == '0);
  assign full   = (sp == AW'(DEPTH));
  assign act    = decodeOp(en, mode, full, empty);
  assign wrAddr = MAW'(sp);
  assign rdAddr = MAW'(sp - AW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp   <= '0;
      ovfQ <= 1'b0;
      udfQ <= 1'b0;
    end else begin
      case (act)
        ACT_PUSH: sp   <= sp + AW'(1);
        ACT_POP:  sp   <= sp - AW'(1);
        ACT_OVF:  ovfQ <= 1'b1;
        ACT_UDF:  udfQ <= 1'b1;
        default:  ;
      endcase
    end
  end

  sr_lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .MAW   (MAW)
  ) uMem (
    .clk    (clk),
    .wrEn   (act == ACT_PUSH),
    .wrAddr (wrAddr),
    .wrData (data_i),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  // Stale storage stays hidden whenever the stack is empty
  assign data_o = empty ? '0 : rdData;
  assign amount = sp;
  assign ovf    = ovfQ;
  assign udf    = udfQ;

endmodule

// File: tb/tb_sr_lifo.sv
// Self-checking bench for sr_lifo: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_sr_lifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic [WIDTH-1:0] data_o;
  logic             empty, full, ovf, udf;
  logic [AW-1:0]    amount;

  int nAsserts = 0;
  int nFails   = 0;
  bit checkOn  = 1'b0;

  logic [WIDTH-1:0] stk[$];
  bit mOvf = 1'b0;
  bit mUdf = 1'b0;

  sr_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data_i(data_i),
    .data_o(data_o), .empty(empty), .full(full), .amount(amount),
    .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAsserts++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue whose back is the top of stack
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stk.delete();
      mOvf = 1'b0;
      mUdf = 1'b0;
    end else if (en) begin
      if (mode) begin
        if (stk.size() == DEPTH) mOvf = 1'b1;
        else stk.push_back(data_i);
      end else begin
        if (stk.size() == 0) mUdf = 1'b1;
        else void'(stk.pop_back());
      end
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      check("cyc.data_o", 32'(data_o), (stk.size() > 0) ? 32'(stk[$]) : 32'd0);
      check("cyc.amount", 32'(amount), 32'(stk.size()));
      check("cyc.empty",  32'(empty),  32'(stk.size() == 0));
      check("cyc.full",   32'(full),   32'(stk.size() == DEPTH));
      check("cyc.ovf",    32'(ovf),    32'(mOvf));
      check("cyc.udf",    32'(udf),    32'(mUdf));
    end
  end

  // All tasks start and end 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    en = 1'b1; mode = 1'b1; data_i = d;
    step();
    en = 1'b0;
  endtask

  task automatic pop(input bit chk, input logic [WIDTH-1:0] exp, input string name);
    en = 1'b1; mode = 1'b0; data_i = $urandom();
    if (chk) check(name, 32'(data_o), 32'(exp));
    step();
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    for (int i = 0; i < n; i++) begin
      mode = $urandom_range(0, 1);
      data_i = $urandom();
      step();
    end
  endtask

  task automatic doReset();
    #1 rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    // Reset then idle
    step();
    rst = 1'b0;
    checkOn = 1'b1;
    doReset();
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("idle.empty", 32'(empty), 32'd1);
      check("idle.full",  32'(full),  32'd0);
      check("idle.amount", 32'(amount), 32'd0);
      check("idle.data_o", 32'(data_o), 32'd0);
      check("idle.flags", 32'({ovf, udf}), 32'd0);
    end

    // Push/pop order
    push(16'h1111); push(16'h2222); push(16'h3333);
    check("order.amount", 32'(amount), 32'd3);
    check("order.top", 32'(data_o), 32'h3333);
    pop(1'b1, 16'h3333, "order.pop1");
    pop(1'b1, 16'h2222, "order.pop2");
    pop(1'b1, 16'h1111, "order.pop3");
    check("order.empty", 32'(empty), 32'd1);
    check("order.data_o", 32'(data_o), 32'd0);

    // Full boundary
    for (int i = 0; i < 16; i++) push(16'(i));
    check("full.full", 32'(full), 32'd1);
    check("full.amount", 32'(amount), 32'd16);
    check("full.top", 32'(data_o), 32'd15);
    push(16'hDEAD);
    check("full.ovf", 32'(ovf), 32'd1);
    check("full.amount2", 32'(amount), 32'd16);
    check("full.top2", 32'(data_o), 32'd15);
    pop(1'b1, 16'd15, "full.pop");
    check("full.amount3", 32'(amount), 32'd15);

    // Empty boundary
    doReset();
    pop(1'b0, '0, "");
    check("empty.udf", 32'(udf), 32'd1);
    check("empty.amount", 32'(amount), 32'd0);
    check("empty.data_o", 32'(data_o), 32'd0);
    push(16'h00AA);
    check("empty.amount2", 32'(amount), 32'd1);
    check("empty.top", 32'(data_o), 32'h00AA);
    check("empty.udfSticky", 32'(udf), 32'd1);

    // Asynchronous reset between edges while a push is requested
    doReset();
    push(16'h5555); push(16'h5555);
    check("arst.pre", 32'(amount), 32'd2);
    en = 1'b1; mode = 1'b1; data_i = 16'h9999;
    #2 rst = 1'b1;
    #1 check("arst.amount", 32'(amount), 32'd0);
    check("arst.empty", 32'(empty), 32'd1);
    check("arst.data_o", 32'(data_o), 32'd0);
    step();
    check("arst.discard", 32'(amount), 32'd0);
    en = 1'b0;
    rst = 1'b0;
    push(16'h7777);
    check("arst.amount2", 32'(amount), 32'd1);
    check("arst.top", 32'(data_o), 32'h7777);

    // Alternating push/pop pairs
    doReset();
    for (int i = 0; i < 8; i++) begin
      d = $urandom();
      push(d);
      check("alt.amount1", 32'(amount), 32'd1);
      pop(1'b1, d, "alt.pop");
      check("alt.amount0", 32'(amount), 32'd0);
    end
    check("alt.flags", 32'({ovf, udf}), 32'd0);

    // Random traffic, biased to reach both boundaries, checked by the model
    doReset();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      mode = (i % 200 < 100) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      data_i = $urandom();
      step();
    end
    en = 1'b0;
    idle(2);

    checkOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
